// File: rtl/vlogic_pipe.sv
// Pipelined RVV bitwise/mask-logical unit with per-byte enables, global stall and token count.
// Results appear LATENCY accepted edges after the operands; sidebands travel with the data.
module vlogic_pipe #(
    parameter int unsigned REQ_DATA_WIDTH  = 64,
    parameter int unsigned RESP_DATA_WIDTH = 64,
    parameter int unsigned REQ_ADDR_WIDTH  = 32,
    parameter int unsigned OPSEL_WIDTH     = 4,
    parameter int unsigned LATENCY         = 6,
    parameter int unsigned CNT_WIDTH       = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_ADDR_WIDTH-1:0]     in_addr,
    input  logic [REQ_DATA_WIDTH-1:0]     in_vec0,
    input  logic [REQ_DATA_WIDTH-1:0]     in_vec1,
    input  logic                          in_valid,
    input  logic [OPSEL_WIDTH-1:0]        in_opSel,
    input  logic [REQ_DATA_WIDTH/8-1:0]   in_be,
    input  logic                          in_sca,
    input  logic                          in_w_reg,
    input  logic                          in_stall,
    output logic [RESP_DATA_WIDTH-1:0]    out_vec,
    output logic                          out_valid,
    output logic [REQ_ADDR_WIDTH-1:0]     out_addr,
    output logic [REQ_DATA_WIDTH/8-1:0]   out_be,
    output logic                          out_w_reg,
    output logic                          out_sca,
    output logic [CNT_WIDTH-1:0]          out_count,
    output logic                          out_busy
);

    localparam int unsigned BeWidth   = REQ_DATA_WIDTH / 8;
    // s1 plus the LATENCY-2 delay stages; the out register follows them.
    localparam int unsigned NumStages = LATENCY - 1;

    localparam logic [OPSEL_WIDTH-1:0] OpAnd  = OPSEL_WIDTH'(1);
    localparam logic [OPSEL_WIDTH-1:0] OpOr   = OPSEL_WIDTH'(2);
    localparam logic [OPSEL_WIDTH-1:0] OpXor  = OPSEL_WIDTH'(3);
    localparam logic [OPSEL_WIDTH-1:0] OpAndn = OPSEL_WIDTH'(4);
    localparam logic [OPSEL_WIDTH-1:0] OpOrn  = OPSEL_WIDTH'(5);
    localparam logic [OPSEL_WIDTH-1:0] OpNand = OPSEL_WIDTH'(6);
    localparam logic [OPSEL_WIDTH-1:0] OpNor  = OPSEL_WIDTH'(7);
    localparam logic [OPSEL_WIDTH-1:0] OpXnor = OPSEL_WIDTH'(8);
    localparam logic [OPSEL_WIDTH-1:0] OpMove = OPSEL_WIDTH'(9);

    typedef struct packed {
        logic                      valid;
        logic [OPSEL_WIDTH-1:0]    op;
        logic [REQ_DATA_WIDTH-1:0] vec0;
        logic [REQ_DATA_WIDTH-1:0] vec1;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [BeWidth-1:0]        be;
        logic                      w_reg;
        logic                      sca;
    } s0_t;

    typedef struct packed {
        logic                       valid;
        logic [RESP_DATA_WIDTH-1:0] data;
        logic [REQ_ADDR_WIDTH-1:0]  addr;
        logic [BeWidth-1:0]         be;
        logic                       w_reg;
        logic                       sca;
    } stage_t;

    s0_t                          s0_d, s0_q;
    stage_t [NumStages-1:0]       pipe_d, pipe_q;
    stage_t                       out_d, out_q;
    logic   [CNT_WIDTH-1:0]       cnt_d, cnt_q;
    logic   [REQ_DATA_WIDTH-1:0]  op_res;

    // Idle slots carry all-zero payloads so the writeback mux sees clean zeros.
    always_comb begin
        s0_d = '0;
        if (in_valid) begin
            s0_d.valid = 1'b1;
            s0_d.op    = in_opSel;
            s0_d.vec0  = in_vec0;
            s0_d.vec1  = in_vec1;
            s0_d.addr  = in_addr;
            s0_d.be    = in_be;
            s0_d.w_reg = in_w_reg;
            s0_d.sca   = in_sca;
        end
    end

    always_comb begin
        op_res = '0;
        case (s0_q.op)
            OpAnd:   op_res = s0_q.vec0 & s0_q.vec1;
            OpOr:    op_res = s0_q.vec0 | s0_q.vec1;
            OpXor:   op_res = s0_q.vec0 ^ s0_q.vec1;
            OpAndn:  op_res = s0_q.vec0 & ~s0_q.vec1;
            OpOrn:   op_res = s0_q.vec0 | ~s0_q.vec1;
            OpNand:  op_res = ~(s0_q.vec0 & s0_q.vec1);
            OpNor:   op_res = ~(s0_q.vec0 | s0_q.vec1);
            OpXnor:  op_res = ~(s0_q.vec0 ^ s0_q.vec1);
            OpMove:  op_res = s0_q.vec1;
            default: op_res = '0;
        endcase
        for (int i = 0; i < BeWidth; i++) begin
            if (!s0_q.be[i]) op_res[i*8 +: 8] = 8'h00;
        end
    end

    always_comb begin
        pipe_d          = '0;
        pipe_d[0].valid = s0_q.valid;
        pipe_d[0].data  = RESP_DATA_WIDTH'(op_res);
        pipe_d[0].addr  = s0_q.addr;
        pipe_d[0].be    = s0_q.be;
        pipe_d[0].w_reg = s0_q.w_reg;
        pipe_d[0].sca   = s0_q.sca;
        for (int i = 1; i < NumStages; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        out_d = pipe_q[NumStages-1];
        cnt_d = cnt_q + CNT_WIDTH'(in_valid) - CNT_WIDTH'(out_q.valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q   <= '0;
            pipe_q <= '0;
            out_q  <= '0;
            cnt_q  <= '0;
        end else if (!in_stall) begin
            s0_q   <= s0_d;
            pipe_q <= pipe_d;
            out_q  <= out_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_vec   = out_q.data;
    assign out_valid = out_q.valid;
    assign out_addr  = out_q.addr;
    assign out_be    = out_q.be;
    assign out_w_reg = out_q.w_reg;
    assign out_sca   = out_q.sca;
    assign out_count = cnt_q;
    assign out_busy  = (cnt_q != '0);

endmodule

// File: tb/tb_vlogic_pipe.sv
// Bench for vlogic_pipe: three instances (LATENCY 6, 2, 16) driven in parallel and compared
// against a sliding-window model over the history of unstalled edges.
module tb_vlogic_pipe;

    typedef struct packed {
        logic        valid;
        logic [63:0] vec;
        logic [31:0] addr;
        logic [7:0]  be;
        logic        w_reg;
        logic        sca;
    } tok_t;

    localparam int NInst = 3;
    localparam int Lat [NInst] = '{6, 2, 16};

    logic        clk, rst;
    logic [31:0] in_addr;
    logic [63:0] in_vec0, in_vec1;
    logic        in_valid, in_sca, in_w_reg, in_stall;
    logic [3:0]  in_opSel;
    logic [7:0]  in_be;

    logic [63:0] o_vec   [NInst];
    logic        o_valid [NInst];
    logic [31:0] o_addr  [NInst];
    logic [7:0]  o_be    [NInst];
    logic        o_w_reg [NInst];
    logic        o_sca   [NInst];
    logic [4:0]  o_count [NInst];
    logic        o_busy  [NInst];

    int   checks = 0;
    int   errors = 0;
    tok_t hist[$];

    vlogic_pipe #(.LATENCY(6)) u_l6 (
        .clk(clk), .rst(rst), .in_addr(in_addr), .in_vec0(in_vec0), .in_vec1(in_vec1),
        .in_valid(in_valid), .in_opSel(in_opSel), .in_be(in_be), .in_sca(in_sca),
        .in_w_reg(in_w_reg), .in_stall(in_stall), .out_vec(o_vec[0]), .out_valid(o_valid[0]),
        .out_addr(o_addr[0]), .out_be(o_be[0]), .out_w_reg(o_w_reg[0]), .out_sca(o_sca[0]),
        .out_count(o_count[0]), .out_busy(o_busy[0])
    );

    vlogic_pipe #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .in_addr(in_addr), .in_vec0(in_vec0), .in_vec1(in_vec1),
        .in_valid(in_valid), .in_opSel(in_opSel), .in_be(in_be), .in_sca(in_sca),
        .in_w_reg(in_w_reg), .in_stall(in_stall), .out_vec(o_vec[1]), .out_valid(o_valid[1]),
        .out_addr(o_addr[1]), .out_be(o_be[1]), .out_w_reg(o_w_reg[1]), .out_sca(o_sca[1]),
        .out_count(o_count[1]), .out_busy(o_busy[1])
    );

    vlogic_pipe #(.LATENCY(16)) u_l16 (
        .clk(clk), .rst(rst), .in_addr(in_addr), .in_vec0(in_vec0), .in_vec1(in_vec1),
        .in_valid(in_valid), .in_opSel(in_opSel), .in_be(in_be), .in_sca(in_sca),
        .in_w_reg(in_w_reg), .in_stall(in_stall), .out_vec(o_vec[2]), .out_valid(o_valid[2]),
        .out_addr(o_addr[2]), .out_be(o_be[2]), .out_w_reg(o_w_reg[2]), .out_sca(o_sca[2]),
        .out_count(o_count[2]), .out_busy(o_busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
        case (op)
            4'd1:    return a & b;
            4'd2:    return a | b;
            4'd3:    return a ^ b;
            4'd4:    return a & ~b;
            4'd5:    return a | ~b;
            4'd6:    return ~(a & b);
            4'd7:    return ~(a | b);
            4'd8:    return ~(a ^ b);
            4'd9:    return b;
            default: return 64'h0;
        endcase
    endfunction

    function automatic tok_t mk_tok(input logic v, input logic [3:0] op, input logic [63:0] a,
                                    input logic [63:0] b, input logic [7:0] be,
                                    input logic [31:0] addr, input logic w, input logic s);
        tok_t        t;
        logic [63:0] m;
        t = '0;
        m = '0;
        if (v) begin
            for (int i = 0; i < 8; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
            t.valid = 1'b1;
            t.vec   = ref_op(op, a, b) & m;
            t.addr  = addr;
            t.be    = be;
            t.w_reg = w;
            t.sca   = s;
        end
        return t;
    endfunction

    // Output after the latest edge is the token from L edges earlier; the count covers
    // every token still occupying s0..out, i.e. the last L+1 edges.
    function automatic logic [112:0] exp_pack(input int l);
        tok_t t;
        int   n, cnt, lo;
        t   = '0;
        n   = hist.size();
        cnt = 0;
        if (n > l) t = hist[n-1-l];
        lo = (n - 1 - l < 0) ? 0 : n - 1 - l;
        for (int i = lo; i < n; i++) cnt += int'(hist[i].valid);
        return {t.valid, t.vec, t.addr, t.be, t.w_reg, t.sca, 5'(cnt), cnt != 0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NInst; k++) begin
            chk($sformatf("%s_L%0d", tag, Lat[k]),
                128'({o_valid[k], o_vec[k], o_addr[k], o_be[k], o_w_reg[k], o_sca[k],
                      o_count[k], o_busy[k]}),
                128'(exp_pack(Lat[k])));
        end
    endtask

    // Called at a falling edge; drives inputs, takes one rising edge, checks at the next fall.
    task automatic step(input string tag, input logic v, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b, input logic [7:0] be,
                        input logic [31:0] addr, input logic w, input logic s, input logic st);
        in_valid = v;  in_opSel = op; in_vec0 = a;  in_vec1 = b;
        in_be    = be; in_addr  = addr; in_w_reg = w; in_sca = s; in_stall = st;
        @(posedge clk);
        if (!rst && !st) hist.push_back(mk_tok(v, op, a, b, be, addr, w, s));
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 4'd0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [3:0]  ops2 [10];
    logic [63:0] ra, rb;

    initial begin
        ops2 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
        rst = 1'b1;
        in_valid = 1'b0; in_opSel = '0; in_vec0 = '0; in_vec1 = '0; in_be = '0;
        in_addr = '0; in_w_reg = 1'b0; in_sca = 1'b0; in_stall = 1'b0;
        @(negedge clk);
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single AND with full byte enables.
        step("t1_acc", 1'b1, 4'd1, 64'hFF00FF00FF00FF00, 64'h0FF00FF00FF00FF0, 8'hFF,
             32'h40, 1'b0, 1'b0, 1'b0);
        idle("t1_wait", 6);
        chk("t1_vec", 128'(o_vec[0]), 128'(64'h0F000F000F000F00));
        chk("t1_valid", 128'(o_valid[0]), 128'(1'b1));
        idle("t1_drain", 12);

        // Every opcode back to back.
        for (int i = 0; i < 10; i++)
            step("t2_ops", 1'b1, ops2[i], 64'hF0F0F0F0F0F0F0F0, 64'hCCCCCCCCCCCCCCCC, 8'hFF,
                 32'(i), 1'b0, 1'b0, 1'b0);
        idle("t2_drain", 18);

        // Partial byte enables.
        step("t3_acc", 1'b1, 4'd3, 64'hFFFFFFFFFFFFFFFF, 64'h0, 8'h0F, 32'h80, 1'b0, 1'b0, 1'b0);
        idle("t3_wait", 6);
        chk("t3_vec", 128'(o_vec[0]), 128'(64'h00000000FFFFFFFF));
        chk("t3_be", 128'(o_be[0]), 128'(8'h0F));
        idle("t3_drain", 12);

        // Three tokens, then a five-cycle stall with garbage presented.
        for (int i = 0; i < 3; i++)
            step("t4_fill", 1'b1, 4'd2, {$urandom, $urandom}, {$urandom, $urandom}, 8'hFF,
                 32'(100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step("t4_stall", 1'b1, 4'd9, {$urandom, $urandom}, {$urandom, $urandom}, 8'hFF,
                 32'hDEAD, 1'b1, 1'b1, 1'b1);
        chk("t4_count", 128'(o_count[0]), 128'(5'd3));
        idle("t4_drain", 18);
        chk("t4_busy", 128'(o_busy[2]), 128'(1'b0));

        // Write/scalar flags only follow valid slots.
        step("t5_acc", 1'b1, 4'd1, 64'h1234, 64'hFFFF, 8'hFF, 32'h10, 1'b1, 1'b1, 1'b0);
        step("t5_idle", 1'b0, 4'd1, 64'h1234, 64'hFFFF, 8'hFF, 32'h20, 1'b1, 1'b1, 1'b0);
        idle("t5_drain", 18);

        // Randomised traffic with occasional stalls.
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            step("rand", $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ra, rb,
                 8'($urandom), $urandom, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 7) == 0);
        end
        idle("rand_drain", 18);

        // Asynchronous reset with tokens in flight.
        for (int i = 0; i < 4; i++)
            step("t6_fill", 1'b1, 4'd3, {$urandom, $urandom}, {$urandom, $urandom}, 8'hFF,
                 32'(200 + i), 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 hist.delete();
        check_all("t6_async");
        chk("t6_count", 128'(o_count[0]), 128'(5'd0));
        @(negedge clk);
        rst = 1'b0;
        idle("t6_after", 20);
        step("t6_first", 1'b1, 4'd6, 64'hAAAA, 64'h5555, 8'hFF, 32'h300, 1'b0, 1'b1, 1'b0);
        idle("t6_first_drain", 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
